// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the 6-bit signed Basic_ALU datapath.
//   DATA_W      operand width
//   data_t      signed two's-complement operand
//   mm_state_t  state encoding of the min/max scanner
package alu_pkg;

   localparam int DATA_W = 6;

   typedef logic signed [DATA_W-1:0] data_t;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      CMP_MAX,
      CMP_MIN,
      DONE
   } mm_state_t;

endpackage

// File: rtl/minmax_seq_if.sv
// minmax_seq_if: operand stream and result handshake of the min/max scanner.
//   in_valid/in_ready/in_data/in_last   operand stream (source -> scanner)
//   res_valid/res_ready                 result handshake (scanner -> consumer)
//   res_max/res_min/res_count           frame result, valid while res_valid=1
//   busy                                scanner is not in IDLE
// master: the sequencer side (operand source and result consumer).
// slave : the scanner itself.
interface minmax_seq_if #(
   parameter int CNT_W = 8
);
   import alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   data_t            in_data;
   logic             in_last;
   logic             res_valid;
   logic             res_ready;
   data_t            res_max;
   data_t            res_min;
   logic [CNT_W-1:0] res_count;
   logic             busy;

   modport master (
      output in_valid, in_data, in_last, res_ready,
      input  in_ready, res_valid, res_max, res_min, res_count, busy
   );

   modport slave (
      input  in_valid, in_data, in_last, res_ready,
      output in_ready, res_valid, res_max, res_min, res_count, busy
   );

endinterface

// File: rtl/signed_gt.sv
// signed_gt: the single signed greater-than comparator of the scanner.
//   a, b  signed operands (data_t)
//   gt    1 when a > b in two's complement, so -32 < ... < -1 < 0 < ... < 31
module signed_gt
   import alu_pkg::*;
(
   input  data_t a,
   input  data_t b,
   output logic  gt
);

   // Both operands are of a signed type, so this is a signed compare.
   assign gt = (a > b);

endmodule

// File: rtl/minmax_seq.sv
// minmax_seq: sequential min/max scanner over a stream of signed operands.
// A frame is a run of operands ending with in_last; the running maximum,
// minimum and saturating operand count are presented on the result port
// once the frame is complete. One comparator is time-shared between the
// max-update (CMP_MAX) and min-update (CMP_MIN) steps.
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    minmax_seq_if slave modport (operand stream, result, busy)
module minmax_seq
   import alu_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   minmax_seq_if.slave bus
);

   mm_state_t        state_q;
   data_t            sample_q;
   logic             last_q;
   data_t            max_q;
   data_t            min_q;
   logic [CNT_W-1:0] cnt_q;
   logic             in_ready_q;
   logic             res_valid_q;
   logic             busy_q;

   data_t            cmp_a;
   data_t            cmp_b;
   logic             cmp_gt;
   logic             accept;

   // Counter increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (&c) return c;
      return c + 1'b1;
   endfunction

   assign accept = bus.in_valid && in_ready_q;

   // Operand muxes: gt(sample, max) in CMP_MAX, gt(min, sample) in CMP_MIN.
   // In other states the comparator output is not consumed.
   always_comb begin
      cmp_a = sample_q;
      cmp_b = max_q;
      if (state_q == CMP_MIN) begin
         cmp_a = min_q;
         cmp_b = sample_q;
      end
   end

   signed_gt u_gt (
      .a  (cmp_a),
      .b  (cmp_b),
      .gt (cmp_gt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         sample_q    <= '0;
         last_q      <= 1'b0;
         max_q       <= '0;
         min_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // First operand seeds both extremes; no compare needed.
               if (accept) begin
                  max_q  <= bus.in_data;
                  min_q  <= bus.in_data;
                  cnt_q  <= CNT_W'(1);
                  busy_q <= 1'b1;
                  if (bus.in_last) begin
                     state_q     <= DONE;
                     in_ready_q  <= 1'b0;
                     res_valid_q <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (accept) begin
                  sample_q   <= bus.in_data;
                  last_q     <= bus.in_last;
                  cnt_q      <= sat_inc(cnt_q);
                  state_q    <= CMP_MAX;
                  in_ready_q <= 1'b0;
               end
            end
            CMP_MAX: begin
               if (cmp_gt) max_q <= sample_q;
               state_q <= CMP_MIN;
            end
            CMP_MIN: begin
               if (cmp_gt) min_q <= sample_q;
               if (last_q) begin
                  state_q     <= DONE;
                  res_valid_q <= 1'b1;
               end else begin
                  state_q    <= WAIT;
                  in_ready_q <= 1'b1;
               end
            end
            DONE: begin
               // Result registers keep their values until the next first accept.
               if (bus.res_ready) begin
                  state_q     <= IDLE;
                  res_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               res_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_max   = max_q;
   assign bus.res_min   = min_q;
   assign bus.res_count = cnt_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_minmax_seq.sv
// tb_minmax_seq: scoreboard bench for minmax_seq. Two instances are used:
// CNT_W=8 (main scenarios) and CNT_W=4 (counter saturation on short frames).
module tb_minmax_seq;
   import alu_pkg::*;

   typedef struct {
      int mx;
      int mn;
      int cnt;
   } exp_t;

   logic  clk = 1'b0;
   logic  reset;
   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;
   data_t ops[$];
   exp_t  sb[$];
   int    acc_q[$];

   minmax_seq_if #(.CNT_W(8)) b8 ();
   minmax_seq_if #(.CNT_W(4)) b4 ();

   minmax_seq #(.CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
   minmax_seq #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // ---------------- access helpers ----------------
   task automatic set_in(input bit sel, input logic v, input data_t d, input logic l);
      if (sel) begin b4.in_valid = v; b4.in_data = d; b4.in_last = l; end
      else     begin b8.in_valid = v; b8.in_data = d; b8.in_last = l; end
   endtask

   task automatic set_rr(input bit sel, input logic r);
      if (sel) b4.res_ready = r; else b8.res_ready = r;
   endtask

   function automatic logic get_rdy(input bit sel);
      return sel ? b4.in_ready : b8.in_ready;
   endfunction
   function automatic logic get_rv(input bit sel);
      return sel ? b4.res_valid : b8.res_valid;
   endfunction
   function automatic logic get_busy(input bit sel);
      return sel ? b4.busy : b8.busy;
   endfunction
   function automatic int get_max(input bit sel);
      return sel ? int'(b4.res_max) : int'(b8.res_max);
   endfunction
   function automatic int get_min(input bit sel);
      return sel ? int'(b4.res_min) : int'(b8.res_min);
   endfunction
   function automatic int get_cnt(input bit sel);
      return sel ? int'(b4.res_count) : int'(b8.res_count);
   endfunction

   task automatic add(input int v);
      ops.push_back(data_t'(v));
   endtask

   // Reference model: signed extremes and saturating count of the frame in ops.
   task automatic push_expected(input int cw);
      exp_t e;
      int   lim;
      lim   = (1 << cw) - 1;
      e.mx  = int'(ops[0]);
      e.mn  = int'(ops[0]);
      for (int i = 1; i < ops.size(); i++) begin
         if (int'(ops[i]) > e.mx) e.mx = int'(ops[i]);
         if (int'(ops[i]) < e.mn) e.mn = int'(ops[i]);
      end
      e.cnt = (ops.size() > lim) ? lim : ops.size();
      sb.push_back(e);
   endtask

   // Offers every operand of ops with in_valid held high, records accept cycles.
   task automatic drive_frame(input bit sel, input bit mark_last);
      acc_q.delete();
      for (int i = 0; i < ops.size(); i++) begin
         int waited = 0;
         set_in(sel, 1'b1, ops[i], mark_last && (i == ops.size() - 1));
         while (!get_rdy(sel) && waited < 50) begin
            @(posedge clk); #1;
            waited++;
         end
         if (waited >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout op %0d: in_ready=0 after 50 cycles, required 1", i);
            set_in(sel, 1'b0, '0, 1'b0);
            return;
         end
         @(posedge clk); #1;
         acc_q.push_back(cyc);
      end
      set_in(sel, 1'b0, '0, 1'b0);
   endtask

   // Waits for the result, compares it with the scoreboard head, then releases it.
   task automatic wait_result(input bit sel, input int exp_lat);
      int   lat = 1;
      exp_t e;
      while (!get_rv(sel) && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      n_checks++;
      if (lat !== exp_lat) begin n_fail++;
         $display("FAIL result_latency: got %0d cycles, expected %0d", lat, exp_lat); end
      if (sb.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL scoreboard_empty: got 0 entries, expected 1");
         return;
      end
      e = sb.pop_front();
      n_checks++;
      if (get_max(sel) !== e.mx) begin n_fail++;
         $display("FAIL res_max: got %0d, expected %0d", get_max(sel), e.mx); end
      n_checks++;
      if (get_min(sel) !== e.mn) begin n_fail++;
         $display("FAIL res_min: got %0d, expected %0d", get_min(sel), e.mn); end
      n_checks++;
      if (get_cnt(sel) !== e.cnt) begin n_fail++;
         $display("FAIL res_count: got %0d, expected %0d", get_cnt(sel), e.cnt); end
      n_checks++;
      if (get_rdy(sel) !== 1'b0) begin n_fail++;
         $display("FAIL done_in_ready: got %0b, expected 0", get_rdy(sel)); end
      set_rr(sel, 1'b1);
      @(posedge clk); #1;
      set_rr(sel, 1'b0);
      n_checks++;
      if (get_rv(sel) !== 1'b0 || get_rdy(sel) !== 1'b1 || get_busy(sel) !== 1'b0) begin n_fail++;
         $display("FAIL release_to_idle: got rv=%0b rdy=%0b busy=%0b, expected rv=0 rdy=1 busy=0",
                  get_rv(sel), get_rdy(sel), get_busy(sel)); end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      set_in(1'b0, 1'b0, '0, 1'b0); set_in(1'b1, 1'b0, '0, 1'b0);
      set_rr(1'b0, 1'b0); set_rr(1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (b8.in_ready !== 1'b1 || b8.res_valid !== 1'b0 || b8.busy !== 1'b0) begin n_fail++;
         $display("FAIL reset_ctrl: got rdy=%0b rv=%0b busy=%0b, expected 1 0 0",
                  b8.in_ready, b8.res_valid, b8.busy); end
      n_checks++;
      if (get_max(0) !== 0 || get_min(0) !== 0 || get_cnt(0) !== 0) begin n_fail++;
         $display("FAIL reset_data: got max=%0d min=%0d cnt=%0d, expected 0 0 0",
                  get_max(0), get_min(0), get_cnt(0)); end
      n_checks++;
      if (get_cnt(1) !== 0 || b4.in_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_dut4: got cnt=%0d rdy=%0b, expected 0 1", get_cnt(1), b4.in_ready); end
   endtask

   task automatic test_basic();
      ops.delete(); add(5); add(-3); add(31); add(-32);
      push_expected(8);
      drive_frame(1'b0, 1'b1);
      n_checks++;
      if (acc_q.size() !== 4) begin n_fail++;
         $display("FAIL basic_accepts: got %0d, expected 4", acc_q.size()); end
      else begin
         n_checks++;
         if (acc_q[1] - acc_q[0] !== 1) begin n_fail++;
            $display("FAIL basic_gap_first: got %0d, expected 1", acc_q[1] - acc_q[0]); end
         for (int i = 2; i < 4; i++) begin
            n_checks++;
            if (acc_q[i] - acc_q[i-1] !== 3) begin n_fail++;
               $display("FAIL basic_gap_%0d: got %0d, expected 3", i, acc_q[i] - acc_q[i-1]); end
         end
      end
      wait_result(1'b0, 3);
   endtask

   task automatic test_single();
      ops.delete(); add(7);
      push_expected(8);
      drive_frame(1'b0, 1'b1);
      wait_result(1'b0, 1);
   endtask

   task automatic test_ties_and_sign();
      ops.delete(); add(-1); add(-1); add(-1);
      push_expected(8);
      drive_frame(1'b0, 1'b1);
      wait_result(1'b0, 3);
      ops.delete(); add(0); add(-32); add(31);
      push_expected(8);
      drive_frame(1'b0, 1'b1);
      wait_result(1'b0, 3);
   endtask

   task automatic test_hold();
      exp_t e;
      int   w = 0;
      ops.delete(); add(4); add(-6);
      push_expected(8);
      drive_frame(1'b0, 1'b1);
      while (!b8.res_valid && w < 20) begin @(posedge clk); #1; w++; end
      e = sb.pop_front();
      set_in(1'b0, 1'b1, data_t'(13), 1'b1);
      set_rr(1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (b8.res_valid !== 1'b1 || b8.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL hold_ctrl cycle %0d: got rv=%0b rdy=%0b, expected 1 0",
                     k, b8.res_valid, b8.in_ready); end
         n_checks++;
         if (get_max(0) !== e.mx || get_min(0) !== e.mn || get_cnt(0) !== e.cnt) begin n_fail++;
            $display("FAIL hold_data cycle %0d: got %0d/%0d/%0d, expected %0d/%0d/%0d", k,
                     get_max(0), get_min(0), get_cnt(0), e.mx, e.mn, e.cnt); end
      end
      set_rr(1'b0, 1'b1);
      @(posedge clk); #1;
      set_rr(1'b0, 1'b0);
      n_checks++;
      if (b8.res_valid !== 1'b0 || b8.in_ready !== 1'b1) begin n_fail++;
         $display("FAIL hold_release: got rv=%0b rdy=%0b, expected 0 1", b8.res_valid, b8.in_ready); end
      ops.delete(); add(13);
      push_expected(8);
      @(posedge clk); #1;
      set_in(1'b0, 1'b0, '0, 1'b0);
      wait_result(1'b0, 1);
   endtask

   task automatic test_reset_mid();
      ops.delete(); add(1); add(2); add(3);
      drive_frame(1'b0, 1'b0);
      @(posedge clk); #1;
      n_checks++;
      if (b8.busy !== 1'b1 || b8.in_ready !== 1'b0) begin n_fail++;
         $display("FAIL mid_frame_busy: got busy=%0b rdy=%0b, expected 1 0", b8.busy, b8.in_ready); end
      reset = 1'b1;
      #1;
      n_checks++;
      if (b8.in_ready !== 1'b1 || b8.res_valid !== 1'b0 || b8.busy !== 1'b0) begin n_fail++;
         $display("FAIL async_reset_ctrl: got rdy=%0b rv=%0b busy=%0b, expected 1 0 0",
                  b8.in_ready, b8.res_valid, b8.busy); end
      n_checks++;
      if (get_max(0) !== 0 || get_min(0) !== 0 || get_cnt(0) !== 0) begin n_fail++;
         $display("FAIL async_reset_data: got %0d/%0d/%0d, expected 0/0/0",
                  get_max(0), get_min(0), get_cnt(0)); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      ops.delete(); add(2); add(9);
      push_expected(8);
      drive_frame(1'b0, 1'b1);
      wait_result(1'b0, 3);
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 4; f++) begin
         int len = $urandom_range(1, 6);
         ops.delete();
         for (int i = 0; i < len; i++) ops.push_back(data_t'($urandom_range(0, 63)));
         push_expected(8);
         drive_frame(1'b0, 1'b1);
         wait_result(1'b0, (len == 1) ? 1 : 3);
      end
   endtask

   task automatic test_saturation();
      ops.delete();
      for (int i = 0; i < 300; i++) ops.push_back(data_t'($urandom_range(0, 63)));
      push_expected(8);
      drive_frame(1'b0, 1'b1);
      wait_result(1'b0, 3);
      ops.delete();
      for (int i = 0; i < 16; i++) ops.push_back(data_t'($urandom_range(8, 40)));
      add(31); add(-32);
      push_expected(4);
      drive_frame(1'b1, 1'b1);
      wait_result(1'b1, 3);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_ties_and_sign();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_saturation();
      n_checks++;
      if (sb.size() !== 0) begin n_fail++;
         $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
